sub_array_tile_loader: RTL and testbench

Streaming loader that accepts one BIT_WIDTH element per handshake in row-major order (row r, col c) for a ROWS x COLS tile. It scatters each element into a flat buffer using the sub-array packing order consumed by the 1D-to-3D sub-array converter. When the tile is complete it presents the whole flat vector with a valid/ready handshake. It sits between an element-serial producer (memory reader or DMA) and the converter's flat input.

---
 rtl/sub_array_tile_loader.sv | 129 ++++++++++++
 tb/tb_sub_array_tile_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sub_array_tile_loader.sv
// Element-serial tile loader: accepts a ROWS x COLS tile in row-major order and
// scatters it into the sub-array packing order, then offers the flat tile via valid/ready.
module sub_array_tile_loader #(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int SUB_ROWS  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [BIT_WIDTH-1:0]            in_data,
    input  logic                            in_valid,
    input  logic                            in_last,
    output logic                            in_ready,
    output logic [ROWS*COLS*BIT_WIDTH-1:0]  out_flat,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(ROWS*COLS+1)-1:0]  elem_count,
    output logic                            last_err
);
    localparam int N  = ROWS * COLS;
    localparam int CW = $clog2(N + 1);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int IW = $clog2(N) + 1;

    typedef enum logic {FILL, HOLD} state_t;

    state_t          state_q;
    logic [RW-1:0]   row_q, row_d;
    logic [XW-1:0]   col_q, col_d;
    logic [CW-1:0]   count_q;
    logic            in_ready_q, out_valid_q, last_err_q;
    logic            accept, at_last_pos;
    logic [IW-1:0]   row_ext, col_ext, idx;
    logic [BIT_WIDTH-1:0] tile_q [N];

    // A flush in the same cycle as a handshake discards the element.
    assign accept      = in_valid && in_ready_q && !flush;
    assign at_last_pos = (row_q == RW'(ROWS - 1)) && (col_q == XW'(COLS - 1));
    assign row_ext     = IW'(row_q);
    assign col_ext     = IW'(col_q);

    always_comb begin
        if (row_ext < IW'(SUB_ROWS)) begin
            idx = col_ext * IW'(SUB_ROWS) + row_ext;
        end else begin
            idx = IW'(COLS * SUB_ROWS) + col_ext * IW'(ROWS - SUB_ROWS) + (row_ext - IW'(SUB_ROWS));
        end
    end

    always_comb begin
        col_d = col_q + XW'(1);
        row_d = row_q;
        if (col_q == XW'(COLS - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            row_q       <= '0;
            col_q       <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            last_err_q  <= 1'b0;
        end else begin
            last_err_q <= 1'b0;
            if (flush) begin
                state_q     <= FILL;
                row_q       <= '0;
                col_q       <= '0;
                count_q     <= '0;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    FILL: begin
                        if (accept) begin
                            last_err_q <= in_last ^ at_last_pos;
                            if (at_last_pos) begin
                                state_q     <= HOLD;
                                row_q       <= '0;
                                col_q       <= '0;
                                count_q     <= '0;
                                in_ready_q  <= 1'b0;
                                out_valid_q <= 1'b1;
                            end else begin
                                row_q   <= row_d;
                                col_q   <= col_d;
                                count_q <= count_q + CW'(1);
                            end
                        end
                    end
                    HOLD: begin
                        if (out_ready) begin
                            state_q     <= FILL;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                        end
                    end
                    default: state_q <= FILL;
                endcase
            end
        end
    end

    // One register slot per packed position; only the addressed slot loads.
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tile_q[gi] <= '0;
            end else if (accept && (idx == IW'(gi))) begin
                tile_q[gi] <= in_data;
            end
        end
        assign out_flat[gi*BIT_WIDTH +: BIT_WIDTH] = tile_q[gi];
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign elem_count = count_q;
    assign last_err   = last_err_q;

endmodule

// File: tb/tb_sub_array_tile_loader.sv
// Directed bench for sub_array_tile_loader: default 8x8/4 instance plus a 6x3/2
// instance fed with random valid gaps.
module tb_sub_array_tile_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, flush, in_valid, in_last, in_ready, out_valid, out_ready, last_err;
    logic [3:0]   in_data;
    logic [255:0] out_flat;
    logic [6:0]   elem_count;

    logic         flush_b, in_valid_b, in_last_b, in_ready_b, out_valid_b, out_ready_b, last_err_b;
    logic [3:0]   in_data_b;
    logic [71:0]  out_flat_b;
    logic [4:0]   elem_count_b;

    int total = 0;
    int bad   = 0;
    logic [255:0] exp_flat;
    logic [71:0]  exp_b;

    sub_array_tile_loader dut (
        .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_flat(out_flat), .out_valid(out_valid),
        .out_ready(out_ready), .elem_count(elem_count), .last_err(last_err)
    );

    sub_array_tile_loader #(.BIT_WIDTH(4), .ROWS(6), .COLS(3), .SUB_ROWS(2)) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_last(in_last_b), .in_ready(in_ready_b), .out_flat(out_flat_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .elem_count(elem_count_b), .last_err(last_err_b)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input int r, input int c, input int nr, input int nc, input int s);
        if (r < s) return c * s + r;
        return nc * s + c * (nr - s) + (r - s);
    endfunction

    function automatic logic [3:0] pat_val(input int pat, input int k);
        case (pat)
            0:       return 4'(k & 15);
            1:       return 4'((k * 3 + 1) & 15);
            default: return 4'hA;
        endcase
    endfunction

    // Feeds n elements starting at (0,0); must be entered on a falling edge.
    task automatic feed(input int n, input int pat, input int last_pos, input bit drop_last);
        int r, c;
        logic [3:0] d;
        bit lst;
        for (int k = 0; k < n; k++) begin
            r = k / 8;
            c = k % 8;
            d = pat_val(pat, k);
            lst = (k == last_pos) || (k == 63 && !drop_last);
            in_valid = 1'b1;
            in_data  = d;
            in_last  = lst;
            chk("in_ready_fill", in_ready, 1);
            @(posedge clk);
            @(negedge clk);
            exp_flat[idx_of(r, c, 8, 8, 4)*4 +: 4] = d;
            chk("last_err", last_err, lst != (k == 63));
            chk("out_valid", out_valid, k == 63);
            chk("elem_count", elem_count, (k + 1) % 64);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int kb, cyc;
        bit acc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        flush_b = 1'b0; in_valid_b = 1'b0; in_last_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;
        exp_flat = '0;
        exp_b = '0;

        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_elem_count", elem_count, 0);
        chk("rst_last_err", last_err, 0);
        chk("rst_out_flat", out_flat, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // Tile 1: ramp pattern, consumer always ready
        feed(64, 0, -1, 1'b0);
        chk("t1_e01", out_flat[19:16], 4'h1);
        chk("t1_e40", out_flat[131:128], 4'h0);
        chk("t1_e51", out_flat[151:148], 4'h9);
        chk("t1_e77", out_flat[255:252], 4'hF);
        chk("t1_flat", out_flat, exp_flat);
        @(posedge clk); @(negedge clk);
        chk("t1_in_ready", in_ready, 1);
        chk("t1_out_valid_drop", out_valid, 0);
        chk("t1_flat_kept", out_flat, exp_flat);
        $display("tile1 done flat=%0h", out_flat);

        // Tile 2: consumer stalls 10 cycles while producer keeps offering
        out_ready = 1'b0;
        feed(64, 1, -1, 1'b0);
        in_valid = 1'b1;
        in_data  = 4'h7;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_flat", out_flat, exp_flat);
            chk("hold_count", elem_count, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);
        chk("rel_count", elem_count, 0);
        $display("tile2 done flat=%0h", out_flat);

        // Tile 3: early in_last on the 10th element, missing in_last on the 64th
        feed(64, 0, 9, 1'b1);
        chk("t3_flat", out_flat, exp_flat);
        @(posedge clk); @(negedge clk);
        $display("tile3 done flat=%0h", out_flat);

        // Flush after 20 accepts, with a coincident handshake that must be dropped
        feed(20, 1, -1, 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_data = 4'h3;
        @(posedge clk); @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", elem_count, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_flat_kept", out_flat, exp_flat);
        feed(64, 2, -1, 1'b0);
        chk("flush_allA", out_flat, {64{4'hA}});
        @(posedge clk); @(negedge clk);
        $display("flush tile done flat=%0h", out_flat);

        // Asynchronous reset mid-tile, observed without any clock edge
        feed(30, 0, -1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_count", elem_count, 0);
        chk("arst_flat", out_flat, 0);
        exp_flat = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("arst_in_ready", in_ready, 1);
        feed(64, 1, -1, 1'b0);
        chk("arst_tile_flat", out_flat, exp_flat);
        $display("post-reset tile done flat=%0h", out_flat);

        // 6x3 instance, SUB_ROWS=2, random valid gaps
        kb = 0;
        cyc = 0;
        while (kb < 18 && cyc < 2000) begin
            in_valid_b = 1'($urandom_range(0, 1));
            in_data_b  = 4'(((kb / 3) * 3 + (kb % 3) + 1) & 15);
            in_last_b  = (kb == 17);
            acc = in_valid_b && in_ready_b;
            @(posedge clk); @(negedge clk);
            if (acc) begin
                exp_b[idx_of(kb / 3, kb % 3, 6, 3, 2)*4 +: 4] = in_data_b;
                kb++;
            end
            cyc++;
        end
        in_valid_b = 1'b0;
        chk("b_accepts", kb, 18);
        chk("b_out_valid", out_valid_b, 1);
        chk("b_count", elem_count_b, 0);
        chk("b_last_err", last_err_b, 0);
        chk("b_e32_idx15", out_flat_b[63:60], 4'hC);
        chk("b_e12_idx5", out_flat_b[23:20], 4'h6);
        chk("b_flat", out_flat_b, exp_b);
        $display("tile b done cycles=%0d flat=%0h", cyc, out_flat_b);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
